// File: rtl/jelly_stream_to_wishbone_pkg.sv
// Shared types for the stream-to-Wishbone master front-end.
package jelly_stream_to_wishbone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Reads always answer; writes answer only when write responses are enabled.
  function automatic logic needs_response(input logic we, input logic write_response);
    return !we || write_response;
  endfunction

endpackage

// File: rtl/jelly_stream_to_wishbone_timeout.sv
// Ack watchdog: counts BUS cycles without ack and flags the final allowed cycle.
module jelly_stream_to_wishbone_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic reset,
  input  logic clk,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam logic [TIMEOUT_WIDTH-1:0] LAST =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  logic [TIMEOUT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + TIMEOUT_WIDTH'(1);
    end
  end

  // count_en already excludes the ack cycle, so a same-cycle ack wins.
  assign expire = (TIMEOUT_CYCLES != 0) && count_en && (count == LAST);

endmodule

// File: rtl/jelly_stream_to_wishbone.sv
// Wishbone classic master front-end: one command beat -> one WB cycle -> optional response beat.
module jelly_stream_to_wishbone
  import jelly_stream_to_wishbone_pkg::*;
#(
  parameter int unsigned WB_ADR_WIDTH   = 12,
  parameter int unsigned WB_DAT_WIDTH   = 32,
  parameter int unsigned WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
  parameter int unsigned WRITE_RESPONSE = 1,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic                    reset,
  input  logic                    clk,

  input  logic [WB_ADR_WIDTH-1:0] s_cmd_adr,
  input  logic                    s_cmd_we,
  input  logic [WB_SEL_WIDTH-1:0] s_cmd_sel,
  input  logic [WB_DAT_WIDTH-1:0] s_cmd_dat,
  input  logic                    s_cmd_valid,
  output logic                    s_cmd_ready,

  output logic [WB_DAT_WIDTH-1:0] m_res_dat,
  output logic                    m_res_err,
  output logic                    m_res_valid,
  input  logic                    m_res_ready,

  output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i,
  output logic                    m_wb_we_o,
  output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
  output logic                    m_wb_stb_o,
  input  logic                    m_wb_ack_i
);

  state_t state;
  logic   timer_expire;

  jelly_stream_to_wishbone_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
  ) u_timeout (
    .reset    (reset),
    .clk      (clk),
    .clear    (state != ST_BUS),
    .count_en ((state == ST_BUS) && !m_wb_ack_i),
    .expire   (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      s_cmd_ready <= 1'b1;
      m_wb_stb_o  <= 1'b0;
      m_wb_adr_o  <= '0;
      m_wb_dat_o  <= '0;
      m_wb_we_o   <= 1'b0;
      m_wb_sel_o  <= '0;
      m_res_valid <= 1'b0;
      m_res_err   <= 1'b0;
      m_res_dat   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_cmd_valid && s_cmd_ready) begin
            m_wb_adr_o  <= s_cmd_adr;
            m_wb_dat_o  <= s_cmd_dat;
            m_wb_we_o   <= s_cmd_we;
            m_wb_sel_o  <= s_cmd_sel;
            m_wb_stb_o  <= 1'b1;
            s_cmd_ready <= 1'b0;
            state       <= ST_BUS;
          end
        end

        ST_BUS: begin
          if (m_wb_ack_i) begin
            m_wb_stb_o <= 1'b0;
            m_res_dat  <= m_wb_we_o ? '0 : m_wb_dat_i;
            m_res_err  <= 1'b0;
            if (needs_response(m_wb_we_o, WRITE_RESPONSE != 0)) begin
              m_res_valid <= 1'b1;
              state       <= ST_RESP;
            end else begin
              s_cmd_ready <= 1'b1;
              state       <= ST_IDLE;
            end
          end else if (timer_expire) begin
            // A timeout is always reported, even for silent writes.
            m_wb_stb_o  <= 1'b0;
            m_res_dat   <= '0;
            m_res_err   <= 1'b1;
            m_res_valid <= 1'b1;
            state       <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (m_res_ready) begin
            m_res_valid <= 1'b0;
            m_res_err   <= 1'b0;
            s_cmd_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        default: begin
          m_wb_stb_o  <= 1'b0;
          m_res_valid <= 1'b0;
          s_cmd_ready <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
